// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue controller: ALU control codes,
// main-decoder ALUOp values, R-type funct values and the controller state type.
package alu_issue_pkg;

    // 4-bit control codes understood by the combinational ALU
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_MULT = 4'b0011;
    localparam logic [3:0] CTRL_SLL  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_SNE  = 4'b1110;
    localparam logic [3:0] CTRL_SRLV = 4'b1111;

    // ALUOp values produced by the main decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SNE   = 3'b101;

    // R-type funct field values
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // funct -> control lookup; entry i of FUNCT_TAB maps to entry i of CTRL_TAB
    localparam int N_FUNCT = 9;
    localparam logic [N_FUNCT-1:0][5:0] FUNCT_TAB = {
        FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_NOR,
        FUNCT_SLT, FUNCT_MULT, FUNCT_SLL, FUNCT_SRLV
    };
    localparam logic [N_FUNCT-1:0][3:0] CTRL_TAB = {
        CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_NOR,
        CTRL_SLT, CTRL_MULT, CTRL_SLL, CTRL_SRLV
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MWAIT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct translator. Produces the ALU control code, a
// multiply flag (selects the multi-cycle hold) and an illegal-encoding flag.
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       is_mult,
    output logic       illegal
);

    logic [N_FUNCT-1:0] funct_hit;
    logic [3:0]         funct_ctrl;

    // One comparator per table entry; the table entries are unique so at
    // most one hit bit is ever set.
    genvar gi;
    generate
        for (gi = 0; gi < N_FUNCT; gi++) begin : g_funct_hit
            assign funct_hit[gi] = (funct == FUNCT_TAB[gi]);
        end
    endgenerate

    // Select the control code of the matching funct entry
    always_comb begin
        funct_ctrl = CTRL_AND;
        for (int i = 0; i < N_FUNCT; i++) begin
            if (funct_hit[i]) begin
                funct_ctrl = CTRL_TAB[i];
            end
        end
    end

    // ALUOp decode; R-type defers to the funct lookup
    always_comb begin
        ctrl    = CTRL_AND;
        is_mult = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD:   ctrl = CTRL_ADD;
            ALUOP_SUB:   ctrl = CTRL_SUB;
            ALUOP_SLT:   ctrl = CTRL_SLT;
            ALUOP_OR:    ctrl = CTRL_OR;
            ALUOP_SNE:   ctrl = CTRL_SNE;
            ALUOP_RTYPE: begin
                ctrl    = funct_ctrl;
                illegal = ~(|funct_hit);
                is_mult = (funct == FUNCT_MULT);
            end
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational ALU. Accepts a decoded
// packet, drives the ALU inputs for the operation's latency (longer for
// multiply), captures result/zero and presents them on a valid/ready output.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  alu_op_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        err_o
);

    localparam int CW = $clog2(MULT_CYCLES) + 1;
    // MWAIT counts down to zero and then spends one cycle in EXEC, so the
    // ALU inputs are held for exactly MULT_CYCLES cycles before capture.
    localparam logic [CW-1:0] CNT_LOAD = (MULT_CYCLES > 1) ? CW'(MULT_CYCLES - 2) : '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]  alu_ctrl_reg, alu_ctrl_next;
    logic [31:0] alu_src1_reg, alu_src1_next;
    logic [31:0] alu_src2_reg, alu_src2_next;
    logic [31:0] result_reg, result_next;
    logic        zero_reg, zero_next;
    logic        err_reg, err_next;

    logic [3:0]  dec_ctrl;
    logic        dec_is_mult;
    logic        dec_illegal;

    alu_op_decode u_decode (
        .alu_op  (alu_op_i),
        .funct   (funct_i),
        .ctrl    (dec_ctrl),
        .is_mult (dec_is_mult),
        .illegal (dec_illegal)
    );

    // State and datapath registers; reset drops any in-flight packet
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            alu_ctrl_reg <= '0;
            alu_src1_reg <= '0;
            alu_src2_reg <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            alu_ctrl_reg <= alu_ctrl_next;
            alu_src1_reg <= alu_src1_next;
            alu_src2_reg <= alu_src2_next;
            result_reg   <= result_next;
            zero_reg     <= zero_next;
            err_reg      <= err_next;
        end
    end

    // Next-state and next-datapath logic; everything holds unless a state acts
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        alu_ctrl_next = alu_ctrl_reg;
        alu_src1_next = alu_src1_reg;
        alu_src2_next = alu_src2_reg;
        result_next   = result_reg;
        zero_next     = zero_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (dec_illegal) begin
                        // Nothing reaches the ALU; report the error directly
                        result_next = '0;
                        zero_next   = 1'b0;
                        err_next    = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        alu_ctrl_next = dec_ctrl;
                        alu_src1_next = src1_i;
                        alu_src2_next = src2_i;
                        if (dec_is_mult && (MULT_CYCLES > 1)) begin
                            cnt_next   = CNT_LOAD;
                            state_next = ST_MWAIT;
                        end else begin
                            state_next = ST_EXEC;
                        end
                    end
                end
            end
            ST_MWAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_EXEC;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_EXEC: begin
                result_next = alu_result_i;
                zero_next   = alu_zero_i;
                err_next    = 1'b0;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_ready_o  = (state_reg == ST_IDLE);
    assign out_valid_o = (state_reg == ST_DONE);
    assign alu_ctrl_o  = alu_ctrl_reg;
    assign alu_src1_o  = alu_src1_reg;
    assign alu_src2_o  = alu_src2_reg;
    assign result_o    = result_reg;
    assign zero_o      = zero_reg;
    assign err_o       = err_reg;

endmodule
